// File: rtl/clk_gate_pkg.sv
// Shared constants for the BUFGCE clock-enable controller: state encoding and
// default settle/drain lengths.
package clk_gate_pkg;

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_ON     = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_BURST  = 3'd4;

    typedef enum logic [2:0] {
        S_OFF    = ST_OFF,
        S_SETTLE = ST_SETTLE,
        S_ON     = ST_ON,
        S_DRAIN  = ST_DRAIN,
        S_BURST  = ST_BURST
    } gate_state_t;

    localparam int unsigned DEF_SETTLE_CYCLES = 2;
    localparam int unsigned DEF_DRAIN_CYCLES  = 4;

endpackage

// File: rtl/clk_gate_ctrl_gate_cnt.sv
// Loadable down-counter with zero flag; times both the settle window and
// the burst length.
module gate_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Registered clock-enable controller for a BUFGCE: settles after enabling,
// drains before gating, and runs fixed-length bursts.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             busy_in,
    output logic             ce,
    output logic             running,
    output logic             ack,
    output logic [CNT_W-1:0] gated_cycles
);

    localparam int unsigned IDLE_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_CYCLES - 1);
    // Counter is loaded with N-1 so that the exit edge is exactly N edges
    // after entry, as the zero flag is observed one edge after loading.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    gate_state_t       state_d, state_q;
    logic              ce_d, ce_q;
    logic              running_d, running_q;
    logic              ack_d, ack_q;
    logic [CNT_W-1:0]  gated_d, gated_q;
    logic [IDLE_W-1:0] idle_d, idle_q;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_dec;
    logic              cnt_zero;

    gate_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        ce_d      = ce_q;
        running_d = running_q;
        ack_d     = 1'b0;
        idle_d    = idle_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        case (state_q)
            S_OFF: begin
                if (burst_start && (burst_len != '0)) begin
                    state_d  = S_BURST;
                    ce_d     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = burst_len - 1'b1;
                end else if (run_req) begin
                    state_d  = S_SETTLE;
                    ce_d     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt_zero) begin
                    state_d   = S_ON;
                    running_d = 1'b1;
                    ack_d     = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_ON: begin
                if (!run_req) begin
                    state_d   = S_DRAIN;
                    running_d = 1'b0;
                    idle_d    = '0;
                end
            end
            S_DRAIN: begin
                // Demand returning wins: CE is still high, so no re-settle.
                if (run_req) begin
                    state_d   = S_ON;
                    running_d = 1'b1;
                    idle_d    = '0;
                end else if (busy_in) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = S_OFF;
                    ce_d    = 1'b0;
                    ack_d   = 1'b1;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_BURST: begin
                if (cnt_zero) begin
                    state_d = S_OFF;
                    ce_d    = 1'b0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d   = S_OFF;
                ce_d      = 1'b0;
                running_d = 1'b0;
                idle_d    = '0;
            end
        endcase
    end

    always_comb begin
        gated_d = gated_q;
        if (!ce_q && (gated_q != {CNT_W{1'b1}})) begin
            gated_d = gated_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            ce_q      <= 1'b0;
            running_q <= 1'b0;
            ack_q     <= 1'b0;
            gated_q   <= '0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            ce_q      <= ce_d;
            running_q <= running_d;
            ack_q     <= ack_d;
            gated_q   <= gated_d;
            idle_q    <= idle_d;
        end
    end

    assign ce           = ce_q;
    assign running      = running_q;
    assign ack          = ack_q;
    assign gated_cycles = gated_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: settle, drain, re-run, burst, ignored
// requests, saturation and mid-operation reset.
module tb_clk_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_req = 1'b0;
    logic        burst_start = 1'b0;
    logic        busy_in = 1'b0;
    logic [15:0] burst_len = '0;
    logic        ce, running, ack;
    logic [15:0] gated_cycles;

    logic        s_zero = 1'b0;
    logic [3:0]  s_len = '0;
    logic        s_ce, s_running, s_ack;
    logic [3:0]  s_gated;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clk_gate_ctrl #(.SETTLE_CYCLES(2), .DRAIN_CYCLES(4), .CNT_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .run_req      (run_req),
        .burst_start  (burst_start),
        .burst_len    (burst_len),
        .busy_in      (busy_in),
        .ce           (ce),
        .running      (running),
        .ack          (ack),
        .gated_cycles (gated_cycles)
    );

    // Narrow instance left idle so its gated-cycle counter saturates.
    clk_gate_ctrl #(.SETTLE_CYCLES(2), .DRAIN_CYCLES(4), .CNT_W(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .run_req      (s_zero),
        .burst_start  (s_zero),
        .burst_len    (s_len),
        .busy_in      (s_zero),
        .ce           (s_ce),
        .running      (s_running),
        .ack          (s_ack),
        .gated_cycles (s_gated)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(1);                                    // edge 0, in reset
        chk("rst_ce", ce, 0);
        chk("rst_running", running, 0);
        chk("rst_ack", ack, 0);
        chk("rst_gated", gated_cycles, 0);
        rst = 1'b0;
        tick(4);                                    // edge 4
        chk("gated_e4", gated_cycles, 4);

        run_req = 1'b1;
        tick(1);                                    // edge 5
        chk("settle_ce", ce, 1);
        chk("settle_running", running, 0);
        chk("gated_e5", gated_cycles, 5);
        tick(1);                                    // edge 6
        chk("settle_mid_run", running, 0);
        chk("settle_mid_ack", ack, 0);
        tick(1);                                    // edge 7
        chk("on_running", running, 1);
        chk("on_ack", ack, 1);
        tick(1);                                    // edge 8
        chk("on_ack_low", ack, 0);
        chk("on_running2", running, 1);

        run_req = 1'b0;
        tick(1);                                    // edge 9
        chk("drain_running", running, 0);
        chk("drain_ce", ce, 1);
        tick(1);                                    // edge 10
        busy_in = 1'b1;
        tick(1);                                    // edge 11
        busy_in = 1'b0;
        tick(3);                                    // edge 14
        chk("drain_busy_ce", ce, 1);
        chk("drain_busy_ack", ack, 0);
        chk("sat_e14", s_gated, 14);
        tick(1);                                    // edge 15
        chk("drain_done_ce", ce, 0);
        chk("drain_done_ack", ack, 1);
        tick(1);                                    // edge 16
        chk("off_ack_low", ack, 0);
        chk("gated_e16", gated_cycles, 6);
        chk("sat_e16", s_gated, 15);

        run_req = 1'b1;
        tick(3);                                    // edge 19
        chk("rerun_running", running, 1);
        chk("rerun_ack", ack, 1);
        run_req = 1'b0;
        tick(1);                                    // edge 20
        chk("redrain_running", running, 0);
        tick(1);                                    // edge 21
        chk("redrain_ce", ce, 1);
        run_req = 1'b1;
        tick(1);                                    // edge 22
        chk("reon_running", running, 1);
        chk("reon_ce", ce, 1);
        chk("reon_ack", ack, 0);
        tick(1);                                    // edge 23
        chk("reon_ack2", ack, 0);
        chk("reon_ce2", ce, 1);

        run_req = 1'b0;
        tick(4);                                    // edge 27
        chk("drain4_ce", ce, 1);
        tick(1);                                    // edge 28
        chk("drain4_off", ce, 0);
        chk("drain4_ack", ack, 1);
        chk("sat_e28", s_gated, 15);

        burst_start = 1'b1; burst_len = 16'd3; run_req = 1'b1;
        tick(1);                                    // edge 29
        chk("burst_ce", ce, 1);
        chk("burst_running", running, 0);
        burst_start = 1'b0; burst_len = '0;
        tick(2);                                    // edge 31
        chk("burst_ce3", ce, 1);
        chk("burst_ack_mid", ack, 0);
        tick(1);                                    // edge 32
        chk("burst_end_ce", ce, 0);
        chk("burst_end_ack", ack, 1);
        tick(1);                                    // edge 33
        chk("defer_settle_ce", ce, 1);
        chk("defer_settle_ack", ack, 0);
        chk("gated_e33", gated_cycles, 9);
        tick(2);                                    // edge 35
        chk("defer_on_run", running, 1);
        chk("defer_on_ack", ack, 1);

        burst_start = 1'b1; burst_len = 16'd5;
        tick(1);                                    // edge 36
        chk("burst_in_on_run", running, 1);
        chk("burst_in_on_ack", ack, 0);
        burst_start = 1'b0; run_req = 1'b0;
        tick(5);                                    // edge 41
        chk("drain5_off", ce, 0);
        chk("drain5_ack", ack, 1);

        burst_start = 1'b1; burst_len = '0;
        tick(1);                                    // edge 42
        chk("burst0_ce", ce, 0);
        run_req = 1'b1;
        tick(1);                                    // edge 43
        chk("burst0_fall_ce", ce, 1);
        chk("burst0_fall_run", running, 0);

        burst_start = 1'b0; rst = 1'b1;
        tick(1);                                    // edge 44
        chk("rst_settle_ce", ce, 0);
        chk("rst_settle_run", running, 0);
        chk("rst_settle_gated", gated_cycles, 0);
        rst = 1'b0; run_req = 1'b0; burst_start = 1'b1; burst_len = 16'd2;
        tick(1);                                    // edge 45
        chk("b2_ce", ce, 1);
        chk("b2_gated", gated_cycles, 1);
        burst_start = 1'b0;
        tick(1);                                    // edge 46
        chk("b2_ce2", ce, 1);
        tick(1);                                    // edge 47
        chk("b2_end_ce", ce, 0);
        chk("b2_end_ack", ack, 1);

        burst_start = 1'b1; burst_len = 16'd4;
        tick(1);                                    // edge 48
        chk("b4_ce", ce, 1);
        burst_start = 1'b0;
        tick(1);                                    // edge 49
        rst = 1'b1;
        tick(1);                                    // edge 50
        chk("rst_burst_ce", ce, 0);
        chk("rst_burst_ack", ack, 0);
        chk("rst_burst_run", running, 0);
        rst = 1'b0; run_req = 1'b1;
        tick(1);                                    // edge 51
        chk("resume_ce", ce, 1);
        tick(2);                                    // edge 53
        chk("resume_run", running, 1);
        chk("resume_ack", ack, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Synchronous controller that produces the registered clock-enable driving a downstream BUFGCE. It turns high-level run/stop and fixed-length burst requests into a glitch-safe CE sequence. Before gating, it waits for the gated domain to settle and to drain. It sits in the free-running `clk` domain, in front of the gated-clock buffer feeding the gated flip-flops, and is the control side of the gated-clock path.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles CE is held high before `running` is reported; ≥1.
- DRAIN_CYCLES, 4: consecutive idle cycles required before CE is dropped; ≥1.
- CNT_W, 16: width of `burst_len` and `gated_cycles`.

Ports:
- clk  in  1  free-running primary clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- run_req  in  1  level; 1 means the gated clock should run.
- burst_start  in  1  single-cycle pulse; requests a burst of exactly `burst_len` enabled cycles.
- burst_len  in  CNT_W  burst length; sampled only with an accepted `burst_start`.
- busy_in  in  1  gated-domain activity flag, already synchronous to `clk`; 1 blocks gating.
- ce  out  1  registered; connects to BUFGCE CE.
- running  out  1  registered; gated clock is enabled and settled.
- ack  out  1  registered single-cycle pulse on each completed settle, drain or burst.
- gated_cycles  out  CNT_W  registered; saturating count of cycles with `ce`=0.

## Operation
- FSM states: OFF, SETTLE, ON, DRAIN, BURST. All outputs are registered and update on the edge at which the FSM transitions.
- OFF (`ce`=0, `running`=0):
  - `burst_start` with `burst_len`≠0: go to BURST and latch the length.
  - Otherwise, if `run_req`=1: go to SETTLE and load the counter with SETTLE_CYCLES.
  - `burst_start` has priority over `run_req`. `burst_start` with `burst_len`=0 is ignored and falls through to the `run_req` check.
- SETTLE (`ce`=1): decrement the counter. At expiry, go to ON with `running`=1 and `ack`=1. A drop of `run_req` during SETTLE does not abort the settle; it is handled in ON.
- ON (`ce`=1, `running`=1): if `run_req`=0, go to DRAIN with `running`=0.
- DRAIN (`ce`=1, `running`=0):
  - The idle counter increments on each cycle with `busy_in`=0 and clears to 0 on `busy_in`=1.
  - On reaching DRAIN_CYCLES: go to OFF with `ce`=0 and `ack`=1.
  - If `run_req` returns to 1: go directly to ON, set `running`=1, no `ack` and no re-settle, since CE never dropped.
- BURST (`ce`=1): decrement the latched length. At zero, go to OFF with `ce`=0 and `ack`=1.
  - `busy_in` and `run_req` are ignored in BURST.
  - `burst_start` is ignored in every state other than OFF.
- `gated_cycles`: increments by 1 on each edge at which the registered `ce`=0. It saturates at 2^CNT_W−1 and never wraps.
- Reset:
  - state OFF; `ce`=0; `running`=0; `ack`=0; `gated_cycles`=0; all internal counters 0.
  - Reset asserted mid-operation drops `ce` after the reset edge, without draining. This is an accepted abrupt gate.

## Timing
- Run: `run_req` sampled high at edge k in OFF.
  - `ce`=1 after edge k.
  - `running`=1 and `ack`=1 after edge k+SETTLE_CYCLES.
  - `ack` is low again after edge k+SETTLE_CYCLES+1.
- Stop: `run_req` sampled low at edge k in ON.
  - `running`=0 after edge k.
  - With `busy_in`=0 throughout, `ce`=0 and `ack`=1 after edge k+DRAIN_CYCLES.
  - Each `busy_in`=1 sample restarts the idle count.
- Burst: `burst_start` sampled at edge k in OFF.
  - `ce`=1 for exactly `burst_len` cycles, from after edge k to after edge k+`burst_len`.
  - `ack`=1 in the cycle after edge k+`burst_len`.
- `ce` changes at most once per cycle. `ce` never toggles without passing through a state transition.
- After a return to OFF, a new request is evaluated from the next edge. Minimum `ce`-low time is 1 cycle.

## Structure
- Shared package/include `clk_gate_pkg`: state encoding localparams and default SETTLE_CYCLES and DRAIN_CYCLES constants.
- One sub-module, `gate_cnt`: a loadable down-counter with a zero flag, shared by SETTLE and BURST.
- The drain idle counter and the `gated_cycles` saturating counter stay inline.

## Test plan
- SETTLE_CYCLES=2: reset, then `run_req`=1 at edge 5 -> `ce`=1 from edge 5, `running` and a 1-cycle `ack` at edge 7; `gated_cycles`=5.
- DRAIN_CYCLES=4: in ON, `run_req`=0 at edge 20 with `busy_in` pulsed high at edge 22 -> `running`=0 at 20, `ce`=0 and `ack` at 26.
- `run_req` re-asserted at DRAIN cycle 2 -> return to ON; `ce` never low; `running`=1; no `ack`.
- `burst_len`=3 with `burst_start` at edge 10 -> `ce` high for exactly 3 cycles, `ack` at 13. A simultaneous `run_req`=1 is deferred and causes SETTLE from edge 14.
- `burst_len`=0 pulse -> ignored. `burst_start` during ON -> ignored. CNT_W=4 idle for 20 cycles -> `gated_cycles` saturates at 15.
- `rst` asserted during SETTLE and during BURST -> all outputs 0 after the reset edge; normal operation resumes on the next request.
